// File: rtl/ahb3lite_sram_arbiter_if.sv
// AHB3-Lite bus bundle between the request arbiter (master) and the
// single-port SRAM slave. HREADY is driven by the master because it is the
// only master on this bus; it simply mirrors HREADYOUT.
interface ahb3lite_sram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic [1:0]        HTRANS;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADYOUT;
    logic              HRESP;

    modport master (
        output HSEL,
        output HADDR,
        output HWRITE,
        output HSIZE,
        output HBURST,
        output HPROT,
        output HTRANS,
        output HWDATA,
        output HREADY,
        input  HRDATA,
        input  HREADYOUT,
        input  HRESP
    );

    modport slave (
        input  HSEL,
        input  HADDR,
        input  HWRITE,
        input  HSIZE,
        input  HBURST,
        input  HPROT,
        input  HTRANS,
        input  HWDATA,
        input  HREADY,
        output HRDATA,
        output HREADYOUT,
        output HRESP
    );
endinterface

// File: rtl/ahb3lite_sram_arbiter.sv
// Round-robin arbiter that shares one AHB3-Lite SRAM slave between NREQ
// request/done clients. Each grant becomes one non-pipelined SINGLE transfer
// (address phase, then data phase). Misaligned or oversized requests are
// rejected locally with err=1 and never reach the bus.
module ahb3lite_sram_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*3-1:0]        size,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic                     err,
    output logic [DATA_W-1:0]        rdata,
    ahb3lite_sram_arbiter_if.master  bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   last_reg;
    logic [IDX_W-1:0]   win_reg;
    logic               we_reg;
    logic [DATA_W-1:0]  wdata_reg;

    // Per-client views of the flattened request buses
    logic [ADDR_W-1:0]  addr_arr  [NREQ];
    logic [2:0]         size_arr  [NREQ];
    logic [DATA_W-1:0]  wdata_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
        assign size_arr[gi]  = size[gi*3 +: 3];
        assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
    end

    // Fixed bus attributes: every transfer is a SINGLE, non-cacheable data access
    assign bus.HBURST = 3'b000;
    assign bus.HPROT  = 4'b0011;
    // Sole master: the slave's HREADY input is its own HREADYOUT
    assign bus.HREADY = bus.HREADYOUT;

    logic [IDX_W-1:0]   win_idx;
    logic               win_found;

    // Round-robin search: first requesting client after the last winner
    always_comb begin : arb_search
        int cand;
        cand      = 0;
        win_idx   = last_reg;
        win_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_reg) + k) % NREQ;
            if (!win_found && req[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    logic [ADDR_W-1:0]  sel_addr;
    logic [2:0]         sel_size;
    logic               sel_legal;

    // Legal = byte, aligned halfword or aligned word; anything else is rejected
    always_comb begin
        sel_addr  = addr_arr[win_idx];
        sel_size  = size_arr[win_idx];
        sel_legal = 1'b0;
        case (sel_size)
            3'b000:  sel_legal = 1'b1;
            3'b001:  sel_legal = (sel_addr[0] == 1'b0);
            3'b010:  sel_legal = (sel_addr[1:0] == 2'b00);
            default: sel_legal = 1'b0;
        endcase
    end

    // Transfer sequencer: all bus and client outputs are registered here
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg  <= S_IDLE;
            last_reg   <= IDX_W'(NREQ - 1);
            win_reg    <= '0;
            we_reg     <= 1'b0;
            wdata_reg  <= '0;
            bus.HSEL   <= 1'b0;
            bus.HTRANS <= HTRANS_IDLE;
            bus.HADDR  <= '0;
            bus.HWRITE <= 1'b0;
            bus.HSIZE  <= 3'b000;
            bus.HWDATA <= '0;
            gnt        <= '0;
            done       <= '0;
            err        <= 1'b0;
            rdata      <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (win_found) begin
                        win_reg   <= win_idx;
                        last_reg  <= win_idx;
                        we_reg    <= we[win_idx];
                        wdata_reg <= wdata_arr[win_idx];
                        gnt       <= ONE_HOT0 << win_idx;
                        if (sel_legal) begin
                            state_reg  <= S_ADDR;
                            bus.HSEL   <= 1'b1;
                            bus.HTRANS <= HTRANS_NONSEQ;
                            bus.HADDR  <= sel_addr;
                            bus.HWRITE <= we[win_idx];
                            bus.HSIZE  <= sel_size;
                        end else begin
                            // Rejected locally: complete next cycle with an error
                            state_reg <= S_RESP;
                            err       <= 1'b1;
                            done      <= ONE_HOT0 << win_idx;
                        end
                    end
                end

                S_ADDR: begin
                    // Address phase is accepted when the slave is ready
                    if (bus.HREADYOUT) begin
                        state_reg  <= S_DATA;
                        bus.HSEL   <= 1'b0;
                        bus.HTRANS <= HTRANS_IDLE;
                        if (we_reg) begin
                            bus.HWDATA <= wdata_reg;
                        end
                    end
                end

                S_DATA: begin
                    // HWDATA is simply held while the slave inserts wait states
                    if (bus.HREADYOUT) begin
                        if (!we_reg) begin
                            rdata <= bus.HRDATA;
                        end
                        err       <= bus.HRESP;
                        done      <= ONE_HOT0 << win_reg;
                        state_reg <= S_RESP;
                    end
                end

                S_RESP: begin
                    done      <= '0;
                    gnt       <= '0;
                    err       <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
